logic_accum: RTL and testbench
==============================

# logic_accum

Parametrised, clocked generalisation of the team's two-input gate blocks. Folds a frame of WIDTH-bit words through one selectable bitwise operator (AND/OR/XOR and their inverses) and returns the word result plus a one-bit reduction. Words arrive one per cycle over a valid/ready stream. Sits between a stimulus source and any consumer of gate-level results, replacing per-gate, per-width modules.

## Interface
- WIDTH, 8, data word width (≥1)
- MAXLEN, 16, maximum words per frame (≥1); CW = $clog2(MAXLEN+1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  WIDTH  operand word
- in_last  in  1  final word of frame
- op  in  3  operator, sampled on first beat of frame: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved (behave as AND)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  frame result word
- out_bit  out  1  reduction of out_data
- out_count  out  CW  words folded into result (1..MAXLEN)
- out_overflow  out  1  frame force-terminated at MAXLEN without in_last

## Operation
- Beat accepted when in_valid && in_ready. in_ready = (state != HOLD).
- States: IDLE, ACCUM, HOLD.
- IDLE: on accept, latch op into op_r; acc <= in_data; cnt <= 1. If in_last, or MAXLEN==1: go HOLD, else ACCUM.
- ACCUM: on accept, acc <= acc BASE(op_r) in_data, where BASE is AND/OR/XOR (inverted ops accumulate with their base op); cnt <= cnt+1. Go HOLD if in_last or cnt+1 == MAXLEN.
- Entering HOLD: out_data <= acc_next, inverted if op_r ∈ {NAND,NOR,XNOR}; out_count <= cnt_next; out_overflow <= (cnt_next==MAXLEN && !in_last); out_valid <= 1.
- out_bit: &out_data for AND/NAND, |out_data for OR/NOR, ^out_data for XOR/XNOR; computed on the stored word (after inversion). Registered with out_data.
- HOLD: outputs stable while out_valid && !out_ready. On out_ready: out_valid <= 0, go IDLE. out_data/out_bit/out_count/out_overflow hold their last values until the next frame completes.
- op changes after the first beat are ignored until the next frame.
- in_valid low mid-frame: state and acc hold; no timeout.
- Reserved op values: identical to AND, no error flag.

## Timing
- Reset (async assert, removal synchronised to clk by the integrator): state IDLE, acc 0, cnt 0, op_r 0, out_valid 0, out_data 0, out_bit 0, out_count 0, out_overflow 0. in_ready is 1 immediately after reset.
- Latency: out_valid rises on the first clk edge after the in_last (or MAXLEN-th) beat is accepted.
- Throughput: one word per cycle within a frame. Minimum inter-frame gap is one cycle (HOLD with out_ready=1). An N-word frame therefore occupies N+1 cycles at full rate.
- in_valid during HOLD is not accepted; the source holds its beat.
- Reset mid-frame or during HOLD discards the partial or pending result; no out_valid follows.
- out_valid never deasserts without an out_ready handshake, except on reset.

## Structure
- Package logic_accum_pkg: op code constants (OP_AND..OP_XNOR), state encodings, function is_inverted(op), function base_of(op).
- Sub-module logic_op_unit: combinational WIDTH-wide two-operand base-op (AND/OR/XOR) selector, used for the accumulate step. The out_bit reduction stays inline.
- Single FSM and datapath registers in logic_accum; no memory.

## Test plan
- WIDTH=8, MAXLEN=4. After reset, check all outputs 0 and in_ready=1. Then send a 1-word AND frame 8'hA5 with last -> next cycle out_valid=1, out_data=A5, out_bit=0, out_count=1, out_overflow=0.
- 3-word XOR frame F0,0F,FF (last on 3rd) -> out_data=00, out_bit=0, out_count=3. Repeat with op=XNOR -> out_data=FF, out_bit=0 (^FF=0).
- 5 NOR words 01,02,04,08,10 with no last -> 4th beat terminates frame: out_data=F0, out_bit=1, out_count=4, out_overflow=1. 5th word starts a new frame.
- Backpressure: hold out_ready=0 for 5 cycles after an OR frame 11,22 -> out_data=33 and out_bit=1 stable, in_ready=0 throughout, then one handshake cycle, then IDLE.
- Change op from AND to OR after the first beat of frame FF,0F -> result 0F (AND kept). op=7 frame FF,3C -> 3C.
- Assert rst for one cycle mid-frame after 2 words -> out_valid stays 0. A new 1-word frame 8'h5A completes with out_count=1.

Source files
------------

// File: rtl/logic_accum_pkg.sv
// rtl/logic_accum_pkg.sv - op codes, FSM states and op-decoding helpers for logic_accum
package logic_accum_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_op_e;

  function automatic logic is_inverted(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  // Reserved codes (6, 7) fall through to AND.
  function automatic base_op_e base_of(input logic [2:0] op);
    case (op)
      OP_OR,  OP_NOR:  return BASE_OR;
      OP_XOR, OP_XNOR: return BASE_XOR;
      default:         return BASE_AND;
    endcase
  endfunction

endpackage

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - combinational two-operand AND/OR/XOR word selector
module logic_op_unit
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  base_op_e         base_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i & b_i;
    case (base_i)
      BASE_OR:  y_o = a_i | b_i;
      BASE_XOR: y_o = a_i ^ b_i;
      default:  y_o = a_i & b_i;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// rtl/logic_accum.sv - folds a stream frame through one bitwise operator into a word and a bit
module logic_accum
  import logic_accum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 16,
  parameter int CW     = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_bit,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_bit_q, out_bit_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_overflow_q, out_overflow_d;

  logic             accept;
  logic             first_beat;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] fold_word;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;
  logic             frame_done;
  logic [WIDTH-1:0] result_word;
  logic             result_bit;

  assign in_ready   = (state_q != ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign first_beat = (state_q == ST_IDLE);

  // The op is only sampled on the first beat; later beats use the latched copy.
  assign op_eff = first_beat ? op : op_q;

  logic_op_unit #(.WIDTH(WIDTH)) u_op_unit (
    .a_i    (acc_q),
    .b_i    (in_data),
    .base_i (base_of(op_q)),
    .y_o    (fold_word)
  );

  assign acc_next   = first_beat ? in_data : fold_word;
  assign cnt_next   = first_beat ? CW'(1) : cnt_q + CW'(1);
  assign frame_done = in_last || (cnt_next == CW'(MAXLEN));

  // Inverted ops fold with their base op and invert once at the end.
  assign result_word = is_inverted(op_eff) ? ~acc_next : acc_next;

  always_comb begin
    result_bit = &result_word;
    case (base_of(op_eff))
      BASE_OR:  result_bit = |result_word;
      BASE_XOR: result_bit = ^result_word;
      default:  result_bit = &result_word;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_bit_d      = out_bit_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (first_beat) begin
            op_d = op;
          end
          acc_d = acc_next;
          cnt_d = cnt_next;
          if (frame_done) begin
            state_d        = ST_HOLD;
            out_valid_d    = 1'b1;
            out_data_d     = result_word;
            out_bit_d      = result_bit;
            out_count_d    = cnt_next;
            out_overflow_d = (cnt_next == CW'(MAXLEN)) && !in_last;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      op_q           <= OP_AND;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_bit_q      <= 1'b0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_bit_q      <= out_bit_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_bit      = out_bit_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_logic_accum.sv
// tb/tb_logic_accum.sv - directed self-checking bench for logic_accum (WIDTH=8, MAXLEN=4)
module tb_logic_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic [2:0] op = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_bit;
  logic [2:0] out_count;
  logic       out_overflow;

  int checks = 0;
  int errors = 0;

  logic_accum #(.WIDTH(8), .MAXLEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bit      (out_bit),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Presents one beat at a negedge and returns at the negedge after it was accepted.
  task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] o);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    op       = o;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%b c=%0d o=%b required all 0",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_and;
    beat(8'hA5, 1'b1, 3'd0);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== {1'b1, 8'hA5, 1'b0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_and: got v=%b d=%h b=%b c=%0d o=%b required v=1 d=a5 b=0 c=1 o=0",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_and_hold_ready: got %b required 0", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_and_release: got v=%b r=%b d=%h required v=0 r=1 d=a5",
               out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_xor_xnor;
    beat(8'hF0, 1'b0, 3'd2);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    beat(8'h0F, 1'b0, 3'd2);
    beat(8'hFF, 1'b1, 3'd2);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count} !== {1'b1, 8'h00, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL xor_frame: got v=%b d=%h b=%b c=%0d required v=1 d=00 b=0 c=3",
               out_valid, out_data, out_bit, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    beat(8'hF0, 1'b0, 3'd5);
    beat(8'h0F, 1'b0, 3'd5);
    beat(8'hFF, 1'b1, 3'd5);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== {1'b1, 8'hFF, 1'b0, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL xnor_frame: got v=%b d=%h b=%b c=%0d o=%b required v=1 d=ff b=0 c=3 o=0",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    beat(8'h01, 1'b0, 3'd4);
    beat(8'h02, 1'b0, 3'd4);
    beat(8'h04, 1'b0, 3'd4);
    beat(8'h08, 1'b0, 3'd4);
    in_data = 8'h10;
    in_last = 1'b1;
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== {1'b1, 8'hF0, 1'b1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL nor_overflow: got v=%b d=%h b=%b c=%0d o=%b required v=1 d=f0 b=1 c=4 o=1",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_hold_ready: got %b required 0", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== {1'b1, 8'hEF, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL fifth_word_new_frame: got v=%b d=%h b=%b c=%0d o=%b required v=1 d=ef b=1 c=1 o=0",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad;
    beat(8'h11, 1'b0, 3'd1);
    beat(8'h22, 1'b1, 3'd1);
    in_data  = 8'h99;
    in_last  = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_bit !== 1'b1 || in_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_stable: %0d unstable cycles, last v=%b d=%h b=%b r=%b required v=1 d=33 b=1 r=0",
               bad, out_valid, out_data, out_bit, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL backpressure_release: got v=%b r=%b d=%h required v=0 r=1 d=33",
               out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_op_latch;
    beat(8'hFF, 1'b0, 3'd0);
    beat(8'h0F, 1'b1, 3'd1);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count} !== {1'b1, 8'h0F, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL op_change_ignored: got v=%b d=%h b=%b c=%0d required v=1 d=0f b=0 c=2",
               out_valid, out_data, out_bit, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    beat(8'hFF, 1'b0, 3'd7);
    beat(8'h3C, 1'b1, 3'd7);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count} !== {1'b1, 8'h3C, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL reserved_op_as_and: got v=%b d=%h b=%b c=%0d required v=1 d=3c b=0 c=2",
               out_valid, out_data, out_bit, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int seen;
    beat(8'h11, 1'b0, 3'd0);
    beat(8'h22, 1'b0, 3'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1 || out_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_frame: out_valid high %0d cycles r=%b c=%0d required 0 cycles r=1 c=0",
               seen, in_ready, out_count);
    end
    beat(8'h5A, 1'b1, 3'd0);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_bit, out_count, out_overflow} !== {1'b1, 8'h5A, 1'b0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_frame: got v=%b d=%h b=%b c=%0d o=%b required v=1 d=5a b=0 c=1 o=0",
               out_valid, out_data, out_bit, out_count, out_overflow);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_and();
    test_xor_xnor();
    test_overflow();
    test_backpressure();
    test_op_latch();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
